// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO buffering the UART bridge's received-byte stream
// for the core. Valid/ready on both sides, first-word-fall-through output.
//
// Optional feature: define UART_RX_FIFO_DROP_EN to accept every byte
// (in_ready tied high), discard bytes that arrive while full, and count
// them on a saturating 8-bit drop_cnt port. Without the macro the FIFO
// back-pressures through in_ready and drop_cnt does not exist.
module uart_rx_fifo #(
    parameter int DEPTH = 16,   // entries, power of two, >= 2
    parameter int AW    = 4     // log2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef UART_RX_FIFO_DROP_EN
    output logic [7:0]    drop_cnt,
`endif
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count == FULL_COUNT);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

`ifdef UART_RX_FIFO_DROP_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = ~full;
`endif

    // A byte is written only when there is room; in drop mode in_ready is
    // always high, so the ~full term is what discards bytes at capacity.
    assign push = in_valid & in_ready & ~full & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Storage write; a full FIFO with a simultaneous pop still refuses the
    // incoming byte, so there is never a pass-through path.
    // NOTE: the memory array has no reset -- only the pointers and count
    // define which entries are valid, and a reset on the array would turn
    // it into flops instead of RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Write/read pointers; AW-bit width makes DEPTH-1 -> 0 wrap automatic.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours regardless of order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy counter: held when push and pop coincide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_RX_FIFO_DROP_EN
    // Saturating count of bytes discarded at capacity; survives flush so
    // software can still read how much input was lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (in_valid && full && !flush && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule
